// File: rtl/perf_pkg.sv
// Shared definitions for the performance-counter bank: event channel
// assignments for the RV32IM pipeline and the default channel count.
package perf_pkg;

    typedef enum logic [1:0] {
        PERF_BR_HIT  = 2'd0,
        PERF_BR_MISS = 2'd1,
        PERF_IC_MISS = 2'd2,
        PERF_DC_MISS = 2'd3
    } perf_event_e;

    localparam int PERF_N_CH_DEFAULT = 4;

endpackage

// File: rtl/perf_counter_cell.sv
// One counter channel: live count, windowed shadow copy and sticky overflow.
// PERF_CNT_SATURATE_EN selects saturating counters; otherwise they wrap.
module perf_counter_cell #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    input  logic             snap,
    output logic [CNT_W-1:0] live,
    output logic [CNT_W-1:0] shadow,
    output logic             ovf
);

    // MSB of the result flags an overflow event, low bits are the next count
    function automatic logic [CNT_W:0] bump(input logic [CNT_W-1:0] v);
`ifdef PERF_CNT_SATURATE_EN
        if (&v) return {1'b1, v};
        return {1'b0, v + CNT_W'(1)};
`else
        return {1'b0, v} + (CNT_W+1)'(1);
`endif
    endfunction

    logic [CNT_W:0]   bumped;
    logic [CNT_W-1:0] live_nxt;

    always_comb begin
        bumped   = bump(live);
        live_nxt = inc ? bumped[CNT_W-1:0] : live;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            live   <= '0;
            shadow <= '0;
            ovf    <= 1'b0;
        end else begin
            if (clr) begin
                live <= '0;
                ovf  <= 1'b0;
            end else begin
                live <= live_nxt;
                if (inc && bumped[CNT_W]) ovf <= 1'b1;
            end
            // snap is already gated by clr at the top level
            if (snap) shadow <= live_nxt;
        end
    end

endmodule

// File: rtl/perf_counter_bank.sv
// N_CH-channel performance-counter bank with windowed snapshots and a
// registered read port. Optional macro: PERF_CNT_SATURATE_EN (saturating counters).
module perf_counter_bank
    import perf_pkg::*;
#(
    parameter  int N_CH   = PERF_N_CH_DEFAULT,
    parameter  int CNT_W  = 32,
    parameter  int WINDOW = 1024,
    localparam int SEL_W  = $clog2(N_CH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_CH-1:0]  event_i,
    input  logic             cpu_stall,
    input  logic             halt,
    input  logic             clr,
    input  logic             rd_en,
    input  logic [SEL_W-1:0] rd_sel,
    output logic [CNT_W-1:0] rd_data,
    output logic             rd_valid,
    output logic [N_CH-1:0]  ovf,
    output logic             snap_valid
);

    localparam int WIN_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;

    logic             en;
    logic             win_term;
    logic             snap;
    logic [WIN_W-1:0] win_cnt;
    logic [CNT_W-1:0] live   [N_CH];
    logic [CNT_W-1:0] shadow [N_CH];
    logic [SEL_W-1:0] ch_sel;
    logic [CNT_W-1:0] rd_mux;

    assign en = ~halt & ~cpu_stall;

    generate
        if (WINDOW == 0) begin : g_no_window
            assign win_term = 1'b0;
        end else begin : g_window
            assign win_term = (win_cnt == WIN_W'(WINDOW - 1));
        end
    endgenerate

    // clr outranks the snapshot so a cleared window never publishes
    assign snap = en & win_term & ~clr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_cnt    <= '0;
            snap_valid <= 1'b0;
        end else begin
            snap_valid <= snap;
            if (clr)           win_cnt <= '0;
            else if (en)       win_cnt <= win_term ? '0 : win_cnt + WIN_W'(1);
        end
    end

    generate
        for (genvar c = 0; c < N_CH; c++) begin : g_ch
            perf_counter_cell #(
                .CNT_W(CNT_W)
            ) u_cell (
                .clk    (clk),
                .rst_n  (rst_n),
                .clr    (clr),
                .inc    (en & event_i[c]),
                .snap   (snap),
                .live   (live[c]),
                .shadow (shadow[c]),
                .ovf    (ovf[c])
            );
        end
    endgenerate

    // MSB picks shadow vs live; unmatched channel indices read as zero
    always_comb begin
        ch_sel            = rd_sel;
        ch_sel[SEL_W-1]   = 1'b0;
        rd_mux            = '0;
        for (int c = 0; c < N_CH; c++) begin
            if (ch_sel == SEL_W'(c)) rd_mux = rd_sel[SEL_W-1] ? shadow[c] : live[c];
        end
    end

    // Read stage: data sampled before this cycle's counter update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) rd_data <= rd_mux;
        end
    end

endmodule

// File: tb/tb_perf_counter_bank.sv
// Directed self-checking bench for perf_counter_bank (N_CH=4, CNT_W=8, WINDOW=16).
module tb_perf_counter_bank;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] event_i = '0;
    logic       cpu_stall = 1'b0;
    logic       halt = 1'b0;
    logic       clr = 1'b0;
    logic       rd_en = 1'b0;
    logic [2:0] rd_sel = '0;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic [3:0] ovf;
    logic       snap_valid;

    int n_cmp = 0;
    int n_bad = 0;

`ifdef PERF_CNT_SATURATE_EN
    localparam logic [7:0] OVF_LIVE = 8'd255;
`else
    localparam logic [7:0] OVF_LIVE = 8'd0;
`endif

    perf_counter_bank #(
        .N_CH   (4),
        .CNT_W  (8),
        .WINDOW (16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .event_i    (event_i),
        .cpu_stall  (cpu_stall),
        .halt       (halt),
        .clr        (clr),
        .rd_en      (rd_en),
        .rd_sel     (rd_sel),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .ovf        (ovf),
        .snap_valid (snap_valid)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_read(input logic [2:0] sel);
        rd_en  = 1'b1;
        rd_sel = sel;
        tick();
        rd_en  = 1'b0;
    endtask

    task automatic do_clr();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) tick();
        n_cmp++;
        if ({rd_data, rd_valid, ovf, snap_valid} !== 14'd0) begin
            n_bad++;
            $display("FAIL reset_outputs: got data=%0d valid=%b ovf=%b snap=%b, want all 0",
                     rd_data, rd_valid, ovf, snap_valid);
        end
        rst_n = 1'b1;
        tick();
        do_read(3'b111);
        n_cmp++;
        if (rd_data !== 8'd0 || rd_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_shadow3: got data=%0d valid=%b, want 0/1", rd_data, rd_valid);
        end
    endtask

    task automatic test_count_read();
        do_clr();
        event_i = 4'b0011;
        repeat (5) tick();
        event_i = 4'b0000;
        do_read(3'd0);
        n_cmp++;
        if (rd_data !== 8'd5 || rd_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL count_ch0: got data=%0d valid=%b, want 5/1", rd_data, rd_valid);
        end
        do_read(3'd1);
        n_cmp++;
        if (rd_data !== 8'd5 || rd_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL count_ch1: got data=%0d valid=%b, want 5/1", rd_data, rd_valid);
        end
        do_read(3'd2);
        n_cmp++;
        if (rd_data !== 8'd0) begin
            n_bad++;
            $display("FAIL count_ch2_idle: got %0d, want 0", rd_data);
        end
        tick();
        n_cmp++;
        if (rd_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL count_valid_drop: got valid=%b, want 0", rd_valid);
        end
    endtask

    task automatic test_stall_halt();
        do_clr();
        event_i   = 4'b0001;
        cpu_stall = 1'b1;
        repeat (3) tick();
        cpu_stall = 1'b0;
        halt      = 1'b1;
        repeat (3) tick();
        halt      = 1'b0;
        repeat (2) tick();
        event_i   = 4'b0000;
        do_read(3'd0);
        n_cmp++;
        if (rd_data !== 8'd2) begin
            n_bad++;
            $display("FAIL freeze_ch0: got %0d, want 2", rd_data);
        end
        halt = 1'b1;
        do_read(3'd0);
        n_cmp++;
        if (rd_data !== 8'd2 || rd_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL read_while_halt: got data=%0d valid=%b, want 2/1", rd_data, rd_valid);
        end
        halt = 1'b0;
    endtask

    task automatic test_window();
        do_clr();
        event_i = 4'b0010;
        for (int t = 1; t <= 16; t++) begin
            tick();
            n_cmp++;
            if (snap_valid !== (t == 16)) begin
                n_bad++;
                $display("FAIL window_snap_t%0d: got %b, want %b", t, snap_valid, (t == 16));
            end
        end
        tick();
        n_cmp++;
        if (snap_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL window_snap_pulse: got %b one cycle later, want 0", snap_valid);
        end
        do_read(3'b101);
        n_cmp++;
        if (rd_data !== 8'd16) begin
            n_bad++;
            $display("FAIL window_shadow1: got %0d, want 16", rd_data);
        end
        do_read(3'b001);
        n_cmp++;
        if (rd_data !== 8'd18) begin
            n_bad++;
            $display("FAIL window_live1: got %0d, want 18", rd_data);
        end
        event_i = 4'b0000;
    endtask

    task automatic test_overflow();
        do_clr();
        event_i = 4'b0100;
        repeat (255) tick();
        n_cmp++;
        if (ovf !== 4'b0000) begin
            n_bad++;
            $display("FAIL ovf_early: got %b, want 0000", ovf);
        end
        tick();
        n_cmp++;
        if (ovf !== 4'b0100 || snap_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL ovf_set: got ovf=%b snap=%b, want 0100/1", ovf, snap_valid);
        end
        event_i = 4'b0000;
        do_read(3'd2);
        n_cmp++;
        if (rd_data !== OVF_LIVE) begin
            n_bad++;
            $display("FAIL ovf_live2: got %0d, want %0d", rd_data, OVF_LIVE);
        end
        n_cmp++;
        if (ovf !== 4'b0100) begin
            n_bad++;
            $display("FAIL ovf_sticky: got %b, want 0100", ovf);
        end
    endtask

    task automatic test_clear_priority();
        event_i = 4'b1111;
        repeat (14) tick();
        clr = 1'b1;
        tick();
        clr     = 1'b0;
        event_i = 4'b0000;
        n_cmp++;
        if (snap_valid !== 1'b0 || ovf !== 4'b0000) begin
            n_bad++;
            $display("FAIL clr_terminal: got snap=%b ovf=%b, want 0/0000", snap_valid, ovf);
        end
        for (int c = 0; c < 4; c++) begin
            do_read(3'(c));
            n_cmp++;
            if (rd_data !== 8'd0) begin
                n_bad++;
                $display("FAIL clr_live%0d: got %0d, want 0", c, rd_data);
            end
        end
        do_read(3'b100);
        n_cmp++;
        if (rd_data !== 8'd0) begin
            n_bad++;
            $display("FAIL clr_shadow0: got %0d, want 0", rd_data);
        end
        do_read(3'b110);
        n_cmp++;
        if (rd_data !== OVF_LIVE) begin
            n_bad++;
            $display("FAIL clr_shadow2: got %0d, want %0d", rd_data, OVF_LIVE);
        end
    endtask

    task automatic test_async_reset();
        do_clr();
        event_i = 4'b0001;
        rd_en   = 1'b1;
        rd_sel  = 3'd0;
        repeat (10) tick();
        n_cmp++;
        if (rd_data !== 8'd9 || rd_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL prereset_read: got data=%0d valid=%b, want 9/1", rd_data, rd_valid);
        end
        #3;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({rd_data, rd_valid, ovf, snap_valid} !== 14'd0) begin
            n_bad++;
            $display("FAIL async_reset: got data=%0d valid=%b ovf=%b snap=%b, want all 0",
                     rd_data, rd_valid, ovf, snap_valid);
        end
        rd_en   = 1'b0;
        event_i = 4'b0000;
        repeat (2) tick();
        rst_n   = 1'b1;
        event_i = 4'b0010;
        for (int t = 1; t <= 16; t++) begin
            tick();
            n_cmp++;
            if (snap_valid !== (t == 16)) begin
                n_bad++;
                $display("FAIL rst_window_t%0d: got %b, want %b", t, snap_valid, (t == 16));
            end
        end
        event_i = 4'b0000;
        do_read(3'b101);
        n_cmp++;
        if (rd_data !== 8'd16) begin
            n_bad++;
            $display("FAIL rst_shadow1: got %0d, want 16", rd_data);
        end
        do_read(3'b110);
        n_cmp++;
        if (rd_data !== 8'd0) begin
            n_bad++;
            $display("FAIL rst_shadow2: got %0d, want 0", rd_data);
        end
        do_read(3'b001);
        n_cmp++;
        if (rd_data !== 8'd16) begin
            n_bad++;
            $display("FAIL rst_live1: got %0d, want 16", rd_data);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_count_read();
        test_stall_halt();
        test_window();
        test_overflow();
        test_clear_priority();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
